// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory bus bundle: entry-in handshake, head-out handshake and forwarding port.
// Latency: none, this is wiring only.
// Backpressure: in_ready flows upstream, out_ready flows from the memory stage.
interface ex_mem_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_result;
    logic                  in_zero;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_reg_write;
    logic                  in_mem_read;
    logic                  in_mem_write;
    logic [DATA_W-1:0]     in_store_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_result;
    logic                  out_zero;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [DATA_W-1:0]     out_store_data;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_rd;
    logic [DATA_W-1:0]     fwd_data;

    // Environment side: produces entries, consumes the head and the forwarding port.
    modport master (
        output in_valid, in_result, in_zero, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_store_data, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data,
               fwd_valid, fwd_rd, fwd_data
    );

    // Stage side.
    modport slave (
        input  in_valid, in_result, in_zero, in_rd, in_reg_write,
               in_mem_read, in_mem_write, in_store_data, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data,
               fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer (main + skid) with forwarding from the head entry.
// Latency: 1 cycle accept-to-out_valid when empty; 1 entry/cycle sustained with out_ready high.
// Backpressure: registered in_ready drops only when both entries are full; optional EX_MEM_STATS_EN adds stall/flush counters.
module ex_mem_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    ex_mem_stage_if.slave bus
`ifdef EX_MEM_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic                  zero;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q;
    entry_t in_entry;
    logic   out_valid;
    logic   accept;
    logic   pop;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // Pack the incoming bus fields into one entry.
    always_comb begin
        in_entry            = '0;
        in_entry.result     = bus.in_result;
        in_entry.zero       = bus.in_zero;
        in_entry.rd         = bus.in_rd;
        in_entry.reg_write  = bus.in_reg_write;
        in_entry.mem_read   = bus.in_mem_read;
        in_entry.mem_write  = bus.in_mem_write;
        in_entry.store_data = bus.in_store_data;
    end

    // Occupancy and storage next-state; flush wins over any accept or pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State registers; in_ready is registered from the next occupancy so it never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_result     = main_q.result;
    assign bus.out_zero       = main_q.zero;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.out_mem_read   = main_q.mem_read;
    assign bus.out_mem_write  = main_q.mem_write;
    assign bus.out_store_data = main_q.store_data;

    // Loads and r0 never forward; loads are resolved by the upstream load-use stall.
    assign bus.fwd_valid = out_valid & main_q.reg_write & ~main_q.mem_read & (main_q.rd != '0);
    assign bus.fwd_rd    = main_q.rd;
    assign bus.fwd_data  = main_q.result;

`ifdef EX_MEM_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters for head stalls and flushes that discard live entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (state_q != EMPTY) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: scoreboard of accepted entries compared at each pop.
// Latency: inputs change 1 time unit after the rising edge, outputs are checked there or on the falling edge.
// Backpressure: scenarios drive out_ready low, high and randomly.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t sb_q[$];

`ifdef EX_MEM_STATS_EN
    logic [31:0] stall_count;
    logic [15:0] flush_count;
`endif

    ex_mem_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
`ifdef EX_MEM_STATS_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic ent_t cur_out();
        ent_t e;
        e.result = bus.out_result;
        e.zero   = bus.out_zero;
        e.rd     = bus.out_rd;
        e.rw     = bus.out_reg_write;
        e.mr     = bus.out_mem_read;
        e.mw     = bus.out_mem_write;
        e.sd     = bus.out_store_data;
        return e;
    endfunction

    function automatic ent_t cur_in();
        ent_t e;
        e.result = bus.in_result;
        e.zero   = bus.in_zero;
        e.rd     = bus.in_rd;
        e.rw     = bus.in_reg_write;
        e.mr     = bus.in_mem_read;
        e.mw     = bus.in_mem_write;
        e.sd     = bus.in_store_data;
        return e;
    endfunction

    function automatic ent_t mk(input logic [31:0] res, input logic [4:0] rd,
                                input logic rw, input logic mr);
        ent_t e;
        e.result = res;
        e.zero   = (res == 32'd0);
        e.rd     = rd;
        e.rw     = rw;
        e.mr     = mr;
        e.mw     = ~rw & ~mr;
        e.sd     = ~res;
        return e;
    endfunction

    task automatic put(input logic v, input ent_t e);
        bus.in_valid      = v;
        bus.in_result     = e.result;
        bus.in_zero       = e.zero;
        bus.in_rd         = e.rd;
        bus.in_reg_write  = e.rw;
        bus.in_mem_read   = e.mr;
        bus.in_mem_write  = e.mw;
        bus.in_store_data = e.sd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: values are stable here until the next rising edge.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && rst === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got result %h exp no output", bus.out_result);
            end else begin
                if (cur_out() !== sb_q[0]) begin
                    errors++;
                    $display("FAIL sb_pop got %h exp %h", cur_out(), sb_q[0]);
                end
                void'(sb_q.pop_front());
            end
        end
        if (rst === 1'b1 || flush === 1'b1) begin
            sb_q.delete();
        end else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            sb_q.push_back(cur_in());
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'h55, 5'd3, 1'b1, 1'b0));
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got v=%b r=%b f=%b exp v=0 r=1 f=0",
                     bus.out_valid, bus.in_ready, bus.fwd_valid);
        end
        checks++;
        if (cur_out() !== '0 || bus.fwd_rd !== 5'd0 || bus.fwd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h fwd %h/%h exp all zero", cur_out(), bus.fwd_rd, bus.fwd_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h55) begin
            errors++;
            $display("FAIL reset_first_accept got v=%b res=%h exp v=1 res=00000055",
                     bus.out_valid, bus.out_result);
        end
        put(1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(1'b1, mk(32'(16 + i), 5'(i + 1), 1'b1, 1'b0));
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready idx %0d got %b exp 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(16 + i)) begin
                errors++;
                $display("FAIL stream_out idx %0d got v=%b res=%h exp v=1 res=%h",
                         i, bus.out_valid, bus.out_result, 32'(16 + i));
            end
        end
        put(1'b0, '0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        ent_t held;
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'hA, 5'd1, 1'b1, 1'b0));
        tick();
        put(1'b1, mk(32'hB, 5'd2, 1'b1, 1'b0));
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_one got %b exp 1", bus.in_ready);
        end
        tick();
        held = cur_out();
        checks++;
        if (bus.in_ready !== 1'b0 || held.result !== 32'hA) begin
            errors++;
            $display("FAIL bp_full got r=%b res=%h exp r=0 res=0000000a", bus.in_ready, held.result);
        end
        put(1'b1, mk(32'hC, 5'd3, 1'b1, 1'b0));
        tick();
        tick();
        checks++;
        if (cur_out() !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable got %h v=%b r=%b exp %h v=1 r=0",
                     cur_out(), bus.out_valid, bus.in_ready, held);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_result !== 32'hB || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_b got res=%h r=%b exp res=0000000b r=1", bus.out_result, bus.in_ready);
        end
        tick();
        put(1'b0, '0);
        checks++;
        if (bus.out_result !== 32'hC || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_c got res=%h v=%b exp res=0000000c v=1", bus.out_result, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'h1, 5'd1, 1'b1, 1'b0));
        tick();
        put(1'b1, mk(32'h2, 5'd2, 1'b1, 1'b0));
        tick();
        put(1'b1, mk(32'h3, 5'd3, 1'b1, 1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        put(1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak cyc %0d got v=%b res=%h exp v=0", i, bus.out_valid, bus.out_result);
            end
        end
        // Flush in ONE with a simultaneous accept and pop.
        put(1'b1, mk(32'h4, 5'd4, 1'b1, 1'b0));
        tick();
        put(1'b1, mk(32'h5, 5'd5, 1'b1, 1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        put(1'b0, '0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_one got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_forwarding();
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'hDEADBEEF, 5'd7, 1'b1, 1'b0));
        tick();
        put(1'b0, '0);
        checks++;
        if (bus.fwd_valid !== 1'b1 || bus.fwd_rd !== 5'd7 || bus.fwd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fwd_alu got v=%b rd=%0d d=%h exp v=1 rd=7 d=deadbeef",
                     bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_empty got %b exp 0", bus.fwd_valid);
        end
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'hDEADBEEF, 5'd7, 1'b1, 1'b1));
        tick();
        put(1'b0, '0);
        checks++;
        if (bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_load got %b exp 0", bus.fwd_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'hDEADBEEF, 5'd0, 1'b1, 1'b0));
        tick();
        put(1'b0, '0);
        checks++;
        if (bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_r0 got %b exp 0", bus.fwd_valid);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        put(1'b1, mk(32'h1234, 5'd9, 1'b0, 1'b0));
        tick();
        put(1'b0, '0);
        checks++;
        if (bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_nowrite got %b exp 0", bus.fwd_valid);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            put(1'($urandom_range(0, 1)),
                mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        put(1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got left=%0d v=%b exp left=0 v=0", sb_q.size(), bus.out_valid);
        end
    endtask

`ifdef EX_MEM_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        put(1'b0, '0);
        tick();
        rst = 1'b0;
        checks++;
        if (stall_count !== 32'd0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d/%0d exp 0/0", stall_count, flush_count);
        end
        put(1'b1, mk(32'h77, 5'd2, 1'b1, 1'b0));
        tick();
        put(1'b0, '0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_count !== 32'd5) begin
            errors++;
            $display("FAIL stats_stall got %0d exp 5", stall_count);
        end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (flush_count !== 16'd1 || stall_count !== 32'd5) begin
            errors++;
            $display("FAIL stats_flush got f=%0d s=%0d exp f=1 s=5", flush_count, stall_count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (flush_count !== 16'd1) begin
            errors++;
            $display("FAIL stats_flush_empty got %0d exp 1", flush_count);
        end
    endtask
`endif

    initial begin
        bus.out_ready = 1'b0;
        put(1'b0, '0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_back_to_back();
`ifdef EX_MEM_STATS_EN
        test_stats();
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage; directly downstream of the 32-bit ALU.
- Captures each ALU result, zero flag and control bundle into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Presents one registered entry to the memory stage.
- Drives a forwarding port back to the execute-stage operand muxes; supports pipeline flush on branch redirect.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_ADDR_W, 5, width of destination register index

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous; discard all buffered entries
- in_valid  input  1  execute stage presents an entry
- in_ready  output  1  stage can accept an entry this cycle
- in_result  input  DATA_W  ALU result
- in_zero  input  1  ALU zero flag
- in_rd  input  REG_ADDR_W  destination register
- in_reg_write  input  1  entry writes register file
- in_mem_read  input  1  entry is a load
- in_mem_write  input  1  entry is a store
- in_store_data  input  DATA_W  store operand
- out_valid  output  1  head entry valid
- out_ready  input  1  memory stage consumes head
- out_result  output  DATA_W  head ALU result
- out_zero  output  1  head zero flag
- out_rd  output  REG_ADDR_W  head destination register
- out_reg_write  output  1  head reg-write flag
- out_mem_read  output  1  head load flag
- out_mem_write  output  1  head store flag
- out_store_data  output  DATA_W  head store data
- fwd_valid  output  1  forwarding data usable
- fwd_rd  output  REG_ADDR_W  forwarded register index
- fwd_data  output  DATA_W  forwarded value

Behaviour:
- Storage: main register (head, drives out_*) and skid register. Occupancy state: EMPTY, ONE, TWO.
- Handshake definitions:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready is registered and equals (state != TWO); it does not depend combinationally on out_ready.
- out_valid = (state != EMPTY).
- State transitions (flush = 0):
  - EMPTY: accept -> ONE, main <= input.
  - ONE: accept & pop -> ONE, main <= input. accept & !pop -> TWO, skid <= input. pop & !accept -> EMPTY. Neither -> hold.
  - TWO: pop -> ONE, main <= skid. No pop -> hold. No accept is possible in TWO.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Sustained throughput is 1 entry/cycle with out_ready held high. Entries leave in strict FIFO order; none are lost or duplicated.
- Stability: while out_valid & !out_ready, all out_* hold stable.
- Flush:
  - Next state is EMPTY; any accept in the same cycle is discarded.
  - in_ready = 1 the following cycle.
  - Flush overrides a simultaneous pop: the consumer sees the pop, but the buffer still empties.
- Reset (any cycle, including mid-transfer):
  - state = EMPTY, in_ready = 1, out_valid = 0.
  - All out_* data/flag outputs and fwd_* = 0.
  - Main and skid registers cleared to 0.
- Data path outputs from an empty buffer: out_* data fields are don't-care, but the implementation drives the last main value (no X propagation).
- Forwarding (combinational from main):
  - fwd_valid = out_valid & out_reg_write & !out_mem_read & (out_rd != 0).
  - fwd_rd = out_rd; fwd_data = out_result.
  - Loads never forward (load-use hazard handled upstream). Register 0 never forwards.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined: adds outputs stall_count [31:0] and flush_count [15:0].
  - stall_count increments each cycle with out_valid & !out_ready.
  - flush_count increments each cycle flush is asserted while state != EMPTY.
  - Both saturate at all-ones and reset to 0 on rst.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, fwd_valid=0, all out_* = 0. First entry accepted only the cycle after rst deasserts.
- Streaming: 8 entries, in_result=0x10..0x17, out_ready=1 throughout -> out_result 0x10..0x17 on consecutive cycles, each 1 cycle after accept; in_ready constantly 1.
- Backpressure: out_ready=0 while sending 0xA, 0xB, 0xC ->
  - 0xA and 0xB accepted; in_ready=0 after the second accept; 0xC is held.
  - Release out_ready -> out_result 0xA, 0xB, 0xC in order; out_* stable during the stall.
- Flush: buffer in TWO (0x1, 0x2); flush=1 with in_valid=1, in_result=0x3 -> next cycle out_valid=0, in_ready=1; 0x3 never appears at the output.
- Forwarding:
  - Head rd=7, reg_write=1, mem_read=0, result=0xDEADBEEF -> fwd_valid=1, fwd_rd=7, fwd_data=0xDEADBEEF.
  - Same entry with mem_read=1 -> fwd_valid=0.
  - Same entry with rd=0 -> fwd_valid=0.
- Stats (EX_MEM_STATS_EN defined): hold out_ready=0 for 5 cycles with 1 entry buffered -> stall_count=5. Then one flush with a non-empty buffer -> flush_count=1.
